// File: rtl/flash_cmd_controller.sv
// Parallel NOR flash command sequencer: read, program, sector erase and reset (F0) with DQ7/DQ5 status polling.
// Define FLASH_POLL_TIMEOUT_EN to abort polling into RECOVER after POLL_MAX unsuccessful status reads.
module flash_cmd_controller #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int STROBE_CYC = 1,
    parameter int POLL_MAX   = 4095
) (
    input  logic              clock_output,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              flash_ce_n,
    output logic              flash_we_n,
    output logic              flash_oe_n,
    output logic [ADDR_W-1:0] flash_addr,
    output logic [DATA_W-1:0] flash_dq_out,
    output logic              flash_dq_oe,
    input  logic [DATA_W-1:0] flash_dq_in
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    // Bus cycles (read and write alike) run phases 0..STROBE_CYC+2.
    localparam logic [4:0] PH_STROBE_END = 5'(STROBE_CYC);
    localparam logic [4:0] PH_HOLD       = 5'(STROBE_CYC + 1);
    localparam logic [4:0] PH_LAST       = 5'(STROBE_CYC + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WCYC,
        S_RCYC,
        S_POLL,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [1:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [2:0]        step_reg;
    logic [4:0]        phase_reg;
    logic [DATA_W-1:0] sample_reg;
    logic              sample_valid_reg;
    logic              retry_reg;
    logic              recover_reg;
    logic              poll_expect;

`ifdef FLASH_POLL_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_MAX + 1);
    logic [PCW-1:0] poll_cnt_reg;
`else
    localparam int unused_poll_max = POLL_MAX;
`endif

    assign poll_expect = (op_reg == OP_PROG) ? wdata_reg[7] : 1'b1;

    function automatic logic [2:0] seq_len(input logic [1:0] op);
        logic [2:0] len;
        case (op)
            OP_PROG:  len = 3'd4;
            OP_ERASE: len = 3'd6;
            default:  len = 3'd1;
        endcase
        return len;
    endfunction

    function automatic logic [ADDR_W-1:0] seq_addr(input logic [1:0] op, input logic [2:0] step,
                                                  input logic [ADDR_W-1:0] target);
        logic [ADDR_W-1:0] a;
        a = target;
        if (op == OP_PROG) begin
            case (step)
                3'd0, 3'd2: a = ADDR_W'(11'h555);
                3'd1:       a = ADDR_W'(11'h2AA);
                default:    a = target;
            endcase
        end else if (op == OP_ERASE) begin
            case (step)
                3'd0, 3'd2, 3'd3: a = ADDR_W'(11'h555);
                3'd1, 3'd4:       a = ADDR_W'(11'h2AA);
                default:          a = target;
            endcase
        end
        return a;
    endfunction

    function automatic logic [DATA_W-1:0] seq_data(input logic [1:0] op, input logic [2:0] step,
                                                  input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] d;
        d = DATA_W'(8'hF0);
        if (op == OP_PROG) begin
            case (step)
                3'd0:    d = DATA_W'(8'hAA);
                3'd1:    d = DATA_W'(8'h55);
                3'd2:    d = DATA_W'(8'hA0);
                default: d = wdata;
            endcase
        end else if (op == OP_ERASE) begin
            case (step)
                3'd0, 3'd3: d = DATA_W'(8'hAA);
                3'd1, 3'd4: d = DATA_W'(8'h55);
                3'd2:       d = DATA_W'(8'h80);
                default:    d = DATA_W'(8'h30);
            endcase
        end
        return d;
    endfunction

    always_ff @(posedge clock_output or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            op_reg           <= OP_READ;
            addr_reg         <= '0;
            wdata_reg        <= '0;
            step_reg         <= '0;
            phase_reg        <= '0;
            sample_reg       <= '0;
            sample_valid_reg <= 1'b0;
            retry_reg        <= 1'b0;
            recover_reg      <= 1'b0;
            cmd_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_error        <= 1'b0;
            flash_ce_n       <= 1'b1;
            flash_we_n       <= 1'b1;
            flash_oe_n       <= 1'b1;
            flash_addr       <= '0;
            flash_dq_out     <= '0;
            flash_dq_oe      <= 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
            poll_cnt_reg     <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_reg      <= cmd_op;
                        addr_reg    <= cmd_addr;
                        wdata_reg   <= cmd_wdata;
                        step_reg    <= 3'd0;
                        phase_reg   <= 5'd0;
                        retry_reg   <= 1'b0;
                        recover_reg <= 1'b0;
                        cmd_ready   <= 1'b0;
                        flash_ce_n  <= 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
                        poll_cnt_reg <= '0;
`endif
                        if (cmd_op == OP_READ) begin
                            state_reg  <= S_RCYC;
                            flash_addr <= cmd_addr;
                        end else begin
                            state_reg    <= S_WCYC;
                            flash_addr   <= seq_addr(cmd_op, 3'd0, cmd_addr);
                            flash_dq_out <= seq_data(cmd_op, 3'd0, cmd_wdata);
                            flash_dq_oe  <= 1'b1;
                        end
                    end
                end

                S_WCYC: begin
                    if (phase_reg != PH_LAST) begin
                        phase_reg  <= phase_reg + 5'd1;
                        flash_we_n <= (phase_reg >= PH_STROBE_END);
                        flash_ce_n <= (phase_reg == PH_HOLD);
                    end else begin
                        phase_reg <= 5'd0;
                        if (recover_reg || op_reg == OP_RESET) begin
                            state_reg   <= S_DONE;
                            flash_dq_oe <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_error   <= recover_reg;
                        end else if (step_reg + 3'd1 < seq_len(op_reg)) begin
                            step_reg     <= step_reg + 3'd1;
                            flash_ce_n   <= 1'b0;
                            flash_addr   <= seq_addr(op_reg, step_reg + 3'd1, addr_reg);
                            flash_dq_out <= seq_data(op_reg, step_reg + 3'd1, wdata_reg);
                        end else begin
                            state_reg        <= S_POLL;
                            flash_dq_oe      <= 1'b0;
                            sample_valid_reg <= 1'b0;
                        end
                    end
                end

                S_RCYC: begin
                    if (phase_reg != PH_LAST) begin
                        phase_reg  <= phase_reg + 5'd1;
                        flash_oe_n <= (phase_reg >= PH_STROBE_END);
                        flash_ce_n <= (phase_reg >= PH_STROBE_END);
                        if (phase_reg == PH_STROBE_END) begin
                            sample_reg <= flash_dq_in;
                        end
                    end else begin
                        phase_reg <= 5'd0;
                        if (op_reg == OP_READ) begin
                            state_reg <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_rdata <= sample_reg;
                        end else begin
                            state_reg        <= S_POLL;
                            sample_valid_reg <= 1'b1;
                        end
                    end
                end

                S_POLL: begin
                    if (sample_valid_reg && sample_reg[7] == poll_expect) begin
                        state_reg <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                    end else if (sample_valid_reg && retry_reg) begin
                        // DQ5 was already flagged on the previous read: the device gave up.
                        state_reg <= S_RECOVER;
`ifdef FLASH_POLL_TIMEOUT_EN
                    end else if (sample_valid_reg && poll_cnt_reg == PCW'(POLL_MAX)) begin
                        state_reg <= S_RECOVER;
`endif
                    end else begin
                        if (sample_valid_reg && sample_reg[5]) begin
                            retry_reg <= 1'b1;
                        end
                        state_reg  <= S_RCYC;
                        phase_reg  <= 5'd0;
                        flash_ce_n <= 1'b0;
                        flash_addr <= addr_reg;
`ifdef FLASH_POLL_TIMEOUT_EN
                        poll_cnt_reg <= poll_cnt_reg + 1'b1;
`endif
                    end
                end

                S_RECOVER: begin
                    state_reg    <= S_WCYC;
                    recover_reg  <= 1'b1;
                    phase_reg    <= 5'd0;
                    flash_ce_n   <= 1'b0;
                    flash_addr   <= addr_reg;
                    flash_dq_out <= DATA_W'(8'hF0);
                    flash_dq_oe  <= 1'b1;
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_error <= 1'b0;
                end

                default: begin
                    state_reg <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
